wb_queue: RTL

- Writeback buffer sitting in front of the three-port register file's single write port (a3/wd3/we3).
- Accepts result writes from two producers, the ALU and the load unit, and queues them in order.
- Drains one entry per cycle into the register file.
- Provides two forwarding lookup ports so decode can read values still pending in the queue.

---
 rtl/wb_queue_if.sv | 34 +++
 rtl/wb_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_queue_if.sv
// Write-request and register-file write-port bundle for the writeback queue.
// The slave modport is the queue side; the master modport is the producer/consumer side.
interface wb_queue_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output we3, a3, wd3
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  we3, a3, wd3
  );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue in front of the register-file write port.
// Takes ALU and load results, drains one per cycle, and forwards pending values to decode.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  wb_queue_if.slave     wb,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_hit,
  output logic          q2_hit,
  output logic [DW-1:0] q1_data,
  output logic [DW-1:0] q2_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] free;
  logic          alu_store, mem_store, pop;
  logic [PW-1:0] mem_idx;
  logic [DW:0]   q1_res, q2_res;

  // Youngest valid entry matching qa; entries are contiguous from rd_ptr, so the last match wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] qa);
    logic [DW:0]   r;
    logic [PW-1:0] idx;
    r = {(DW + 1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((qa != {AW{1'b0}}) && vld_q[idx] && (addr_q[idx] == qa)) begin
        r = {1'b1, data_q[idx]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign free         = CW'(DEPTH) - count_q;
  assign wb.alu_ready = (free >= CW'(1));
  assign wb.mem_ready = wb.alu_valid ? (free >= CW'(2)) : (free >= CW'(1));
  assign alu_store    = wb.alu_valid && wb.alu_ready && (wb.alu_addr != {AW{1'b0}});
  assign mem_store    = wb.mem_valid && wb.mem_ready && (wb.mem_addr != {AW{1'b0}});
  assign pop          = (count_q != {CW{1'b0}});
  assign mem_idx      = wr_ptr_q + PW'(alu_store);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    vld_d[rd_ptr_q] = vld_q[rd_ptr_q] & ~pop;
    if (alu_store) begin
      addr_d[wr_ptr_q] = wb.alu_addr;
      data_d[wr_ptr_q] = wb.alu_data;
      vld_d[wr_ptr_q]  = 1'b1;
    end else begin
      addr_d[wr_ptr_q] = addr_q[wr_ptr_q];
    end
    if (mem_store) begin
      addr_d[mem_idx] = wb.mem_addr;
      data_d[mem_idx] = wb.mem_data;
      vld_d[mem_idx]  = 1'b1;
    end else begin
      addr_d[mem_idx] = addr_d[mem_idx];
    end
    wr_ptr_d = wr_ptr_q + PW'(alu_store) + PW'(mem_store);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(alu_store) + CW'(mem_store) - CW'(pop);
  end

  // State registers; reset discards every pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
      vld_q    <= {DEPTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wb.we3 = pop;
  assign wb.a3  = pop ? addr_q[rd_ptr_q] : {AW{1'b0}};
  assign wb.wd3 = pop ? data_q[rd_ptr_q] : {DW{1'b0}};

  assign q1_res  = lookup(q1_addr);
  assign q2_res  = lookup(q2_addr);
  assign q1_hit  = q1_res[DW];
  assign q1_data = q1_res[DW-1:0];
  assign q2_hit  = q2_res[DW];
  assign q2_data = q2_res[DW-1:0];

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
endmodule
